// File: rtl/image_rom_arbiter_if.sv
// Bus bundle between the ImageROM arbiter and its CPU, pixel-consumer and ROM neighbours.
interface image_rom_arbiter_if;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        st_start;
  logic [31:0] st_base;
  logic [31:0] st_count;
  logic        st_busy;
  logic        st_done;
  logic        st_err;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic [31:0] rom_addr;
  logic [31:0] rom_rd;

  modport slave (
    input  cpu_req, cpu_addr, st_start, st_base, st_count, s_ready, rom_rd,
    output cpu_gnt, cpu_rvalid, cpu_rdata, st_busy, st_done, st_err,
           s_valid, s_data, s_last, rom_addr
  );

  modport master (
    output cpu_req, cpu_addr, st_start, st_base, st_count, s_ready, rom_rd,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, st_busy, st_done, st_err,
           s_valid, s_data, s_last, rom_addr
  );
endinterface

// File: rtl/image_rom_arbiter.sv
// Shares the single-port ImageROM between CPU loads (priority) and a block stream
// engine with valid/ready output; a starvation counter forces occasional stream slots.
module image_rom_arbiter #(
  parameter int unsigned IMG_DEPTH  = 160000,
  parameter int unsigned STARVE_LIM = 4
) (
  input logic                clk,
  input logic                rst,
  image_rom_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam int unsigned SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

  logic [1:0]    state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   rem_q, rem_d;
  logic [31:0]   s_data_q, s_data_d;
  logic [31:0]   cpu_rdata_q, cpu_rdata_d;
  logic          s_valid_q, s_valid_d;
  logic          s_last_q, s_last_d;
  logic          st_err_q, st_err_d;
  logic          st_done_q, st_done_d;
  logic          cpu_rvalid_q, cpu_rvalid_d;
  logic [SW-1:0] starve_q, starve_d;

  logic        st_want, st_gnt, cpu_gnt, start_acc, in_range;
  logic [31:0] rom_addr, rd_masked;

  always_comb begin
    st_want   = (state_q == S_RUN) && (rem_q != '0) && (!s_valid_q || bus.s_ready);
    st_gnt    = st_want && (!bus.cpu_req || (starve_q == SW'(STARVE_LIM)));
    cpu_gnt   = bus.cpu_req && !st_gnt && !rst;
    rom_addr  = rst ? '0 : (cpu_gnt ? bus.cpu_addr : addr_q);
    in_range  = rom_addr < IMG_DEPTH;
    rd_masked = in_range ? bus.rom_rd : '0;
    // A start coinciding with the done pulse is dropped, as is any start while busy.
    start_acc = bus.st_start && (state_q == S_IDLE) && !st_done_q;
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    s_data_d     = s_data_q;
    s_valid_d    = s_valid_q;
    s_last_d     = s_last_q;
    st_err_d     = st_err_q;
    st_done_d    = 1'b0;
    cpu_rvalid_d = cpu_gnt;
    cpu_rdata_d  = cpu_gnt ? rd_masked : cpu_rdata_q;
    starve_d     = (st_want && !st_gnt) ? starve_q + SW'(1) : '0;

    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          addr_d   = bus.st_base;
          rem_d    = bus.st_count;
          st_err_d = 1'b0;
          state_d  = (bus.st_count == '0) ? S_FLUSH : S_RUN;
        end
      end
      S_RUN: begin
        if (s_valid_q && bus.s_ready) s_valid_d = 1'b0;
        if (st_gnt) begin
          s_data_d  = rd_masked;
          s_valid_d = 1'b1;
          s_last_d  = (rem_q == 32'd1);
          addr_d    = addr_q + 32'd1;
          rem_d     = rem_q - 32'd1;
          if (!in_range) st_err_d = 1'b1;
          if (rem_q == 32'd1) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // Zero-length streams arrive here with no beat pending and finish at once.
        if (!s_valid_q || bus.s_ready) begin
          s_valid_d = 1'b0;
          s_last_d  = 1'b0;
          st_done_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      s_data_q     <= '0;
      s_valid_q    <= 1'b0;
      s_last_q     <= 1'b0;
      st_err_q     <= 1'b0;
      st_done_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      starve_q     <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      s_data_q     <= s_data_d;
      s_valid_q    <= s_valid_d;
      s_last_q     <= s_last_d;
      st_err_q     <= st_err_d;
      st_done_q    <= st_done_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      starve_q     <= starve_d;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.st_busy    = (state_q != S_IDLE);
  assign bus.st_done    = st_done_q;
  assign bus.st_err     = st_err_q;
  assign bus.s_valid    = s_valid_q;
  assign bus.s_data     = s_data_q;
  assign bus.s_last     = s_last_q;
  assign bus.rom_addr   = rom_addr;
endmodule
